// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: one-hot frame
// states, parity codes and the parity-enable helper.
package uart_pkg;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic parity_en(input int code);
    return (code == PAR_ODD) || (code == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data LSB first, optional parity, 1 or 2 stop
// bits, timed by an oversampled tick from the shared baud generator.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (low)
// DATA   | driving shift_reg[bit_index]
// PARITY | driving the parity bit (odd = XOR, even = XNOR of the data)
// STOP   | driving stop bit(s) high
// DONE   | one-clk completion pulse, then back to IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD              = 9600,
  parameter int clk_freq          = 50_000_000,
  parameter int oversampling_rate = 16,
  parameter int data_wd           = 8,
  parameter int parity            = 1,
  parameter int stop_bits         = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               tx_start,
  input  logic [data_wd-1:0] din,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int TW = $clog2(oversampling_rate);
  localparam int BW = $clog2(data_wd);
  localparam logic [TW-1:0] TICK_LAST = TW'(oversampling_rate - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(data_wd - 1);
  localparam logic PAR_ON   = parity_en(parity);
  localparam logic TWO_STOP = (stop_bits == 2);

  if (oversampling_rate < 2 || data_wd < 5 || data_wd > 9 || BAUD < 1 || clk_freq < BAUD)
  begin : g_bad_param
    $error("uart_tx: illegal parameter combination");
  end

  state_t             state, state_n;
  logic [TW-1:0]      tick_count, tick_count_n;
  logic [BW-1:0]      bit_index, bit_index_n;
  logic               stop_count, stop_count_n;
  logic [data_wd-1:0] shift_reg, shift_reg_n;
  logic               tx_r, tx_n;
  logic               bit_end;
  logic               par_bit;

  assign bit_end = tick && (tick_count == TICK_LAST);
  assign par_bit = (parity == PAR_ODD) ? ^shift_reg : ~^shift_reg;

  always_comb begin
    state_n      = state;
    tick_count_n = tick_count;
    bit_index_n  = bit_index;
    stop_count_n = stop_count;
    shift_reg_n  = shift_reg;

    // The counter restarts at every bit boundary, so non-power-of-two rates work.
    if (state != IDLE && state != DONE && tick)
      tick_count_n = bit_end ? '0 : tick_count + 1'b1;

    unique case (state)
      IDLE: begin
        if (tx_start) begin
          shift_reg_n  = din;
          tick_count_n = '0;
          bit_index_n  = '0;
          stop_count_n = 1'b0;
          state_n      = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_index_n = '0;
          state_n     = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_index == BIT_LAST)
            state_n = PAR_ON ? PARITY : STOP;
          else
            bit_index_n = bit_index + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end)
          state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (TWO_STOP && !stop_count)
            stop_count_n = 1'b1;
          else
            state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // The line level is computed from the next state so tx changes on the same edge.
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg_n[bit_index_n];
      PARITY:  tx_n = par_bit;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_count <= '0;
      bit_index  <= '0;
      stop_count <= 1'b0;
      shift_reg  <= '0;
      tx_r       <= 1'b1;
    end else begin
      state      <= state_n;
      tick_count <= tick_count_n;
      bit_index  <= bit_index_n;
      stop_count <= stop_count_n;
      shift_reg  <= shift_reg_n;
      tx_r       <= tx_n;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = (state != IDLE) && (state != DONE);
  assign tx_done = (state == DONE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter. Accepts one parallel word per frame and shifts out start bit, data bits LSB first, optional parity, and stop bit(s) on a single line. Bit timing comes from the shared baud generator's oversampled tick (oversampling_rate ticks per bit). It is the transmit half paired with the existing UART receiver and uses the same tick, parameters and parity coding.

Parameters:
BAUD, 9600, baud rate; informational only, since timing comes solely from tick.
clk_freq, 50_000_000, system clock frequency in Hz; informational.
oversampling_rate, 16, ticks per bit period; must be at least 2.
data_wd, 8, data bits per frame, 5 to 9.
parity, 1, 1 = "odd" code, 2 = "even" code, any other value = no parity bit.
stop_bits, 1, 1 or 2; any other value is treated as 1.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous and active-high (fixed decision; one clock domain)
tick  input  1  one-clk pulse from the baud generator, oversampling_rate per bit
tx_start  input  1  request to send din; sampled only in IDLE
din  input  data_wd  parallel data, captured on an accepted tx_start
tx  output  1  serial line, registered, idles high
tx_busy  output  1  high from the cycle after acceptance until the cycle tx_done is asserted
tx_done  output  1  one-clk pulse marking frame complete

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_done=0; internally state=IDLE, all counters 0, shift register 0.
- Reset mid-frame: the line returns high immediately (asynchronously). The partial frame is abandoned; nothing is resumed.
- States are one-hot 6-bit: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - tx=1, tx_done=0.
  - When tx_start=1 at clk edge n: capture din into the shift register, clear tick_count and bit_index, and go to START.
  - From edge n+1: tx=0 and tx_busy=1.
  - tick is ignored in IDLE.
- Bit timing:
  - tick_count increments on each tick and is cleared on every state change.
  - A bit ends on the tick where tick_count==oversampling_rate-1. The state or bit then advances on that same edge.
  - Each bit therefore lasts exactly oversampling_rate ticks after the first tick following entry.
  - Cycles with tick=0 hold all state.
- START: tx=0. At the end of the bit, go to DATA with bit_index=0.
- DATA:
  - tx = shift_reg[bit_index], so data goes out LSB first.
  - At each bit end, bit_index increments.
  - At the end of the bit where bit_index==data_wd-1, go to PARITY if parity is 1 or 2, otherwise go to STOP.
- PARITY:
  - parity=1: tx = XOR-reduce of the captured data.
  - parity=2: tx = XNOR-reduce of the captured data.
  - This is the exact code the receiver checks. At the end of the bit, go to STOP.
- STOP:
  - tx=1 for stop_bits bit periods; a stop_count is used when stop_bits=2.
  - After the last stop bit ends, go to DONE.
- DONE:
  - For one clk: tx=1, tx_done=1, tx_busy=0. Then go to IDLE unconditionally.
  - The earliest next tx_start is accepted in the IDLE cycle after DONE.
- tx_start while busy, including during DONE, is ignored. It is not queued.
- din changes after acceptance have no effect on the frame in flight.
- tick coinciding with tx_start in IDLE: the tick is not counted.
- Frame length: (1 + data_wd + parity_en + stop_bits) * oversampling_rate ticks, plus 1 clk for DONE.
- tx is driven from a register only, so it is glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - the one-hot state localparams IDLE..DONE, common with the receiver;
  - parity codes PAR_ODD=1, PAR_EVEN=2;
  - a parity_en function of the parity code.
- No sub-module is needed. The tick counter, bit index and stop counter stay inline, which is about 150 RTL lines.

Test Plan:
- Frame 8O1: tick tied high, oversampling_rate=16, parity=1, din=8'hA5, pulse tx_start.
  - tx sequence per 16 clks: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop).
  - tx_done pulses exactly 176 clks after tx goes low; tx_busy is high throughout.
- Even code: parity=2, din=8'hA5 -> parity bit 1. Parity=0, din=8'h00 -> 10 bits, then tx_done at 160 clks.
- Sparse ticks: tick every 4th clk, stop_bits=2, parity=0, din=8'hFF.
  - Each bit lasts 64 clks; tx stays low only during the start bit.
  - The frame lasts 11*64 clks.
- Busy guard: assert tx_start again mid-DATA with din=8'h3C.
  - The original frame completes unchanged and no second frame starts.
  - Back-to-back: tx_start in the IDLE cycle right after tx_done produces a contiguous next frame.
- Async reset: assert rst mid-DATA between clk edges.
  - tx=1, tx_busy=0, tx_done=0 immediately.
  - After release, tx stays high until a new tx_start.
- Receiver loopback: connect tx to the UART receiver with the same parameters and a shared tick; send 16 random words with parity 1 and 2.
  - dout matches din for every word.
  - parity_error_flag=0 and framing_error_flag=0 throughout.
